// File: rtl/sha256_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sha256_ctrl_pkg
// Shared definitions for the SHA-256 block controller:
//   - state_t      : controller FSM encoding
//   - NUM_WORDS    : message schedule words loaded per block (16)
//   - NUM_ROUNDS   : maximum compression rounds per block (64)
//   - DIGEST_BYTES : bytes streamed to the transmitter per digest (32)
//   - is_tx()      : true for the two byte-transmit states
// -----------------------------------------------------------------------------
package sha256_ctrl_pkg;

    localparam int NUM_WORDS    = 16;
    localparam int NUM_ROUNDS   = 64;
    localparam int DIGEST_BYTES = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_TX_START,
        ST_TX_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic is_tx(input state_t s);
        return (s == ST_TX_START) || (s == ST_TX_WAIT);
    endfunction

endpackage

// File: rtl/sha256_tx_seq.sv
// -----------------------------------------------------------------------------
// sha256_tx_seq
// Digest byte sequencer. Keeps the byte counter (0..31) while the controller
// is in TX_START/TX_WAIT and produces the registered transmitter controls.
// Ports:
//   clk, rst_n      clock; synchronous active-high reset (1 = reset)
//   state_reg       controller state this cycle
//   state_next      controller state after this edge
//   tx_done_in      transmitter byte-complete pulse (used only in TX_WAIT)
//   last_byte       combinational: counter points at the final digest byte
//   tx_start        registered one-cycle start pulse (high in TX_START)
//   dig_sel         registered digest word select, byte / 4
//   tx_byte_sel     registered byte-in-word select, byte % 4 (0 = MSB)
// -----------------------------------------------------------------------------
module sha256_tx_seq
    import sha256_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  state_t     state_reg,
    input  state_t     state_next,
    input  logic       tx_done_in,
    output logic       last_byte,
    output logic       tx_start,
    output logic [2:0] dig_sel,
    output logic [1:0] tx_byte_sel
);

    localparam int BYTE_W = $clog2(DIGEST_BYTES);

    logic [BYTE_W-1:0] byte_cnt_reg;
    logic [BYTE_W-1:0] byte_cnt_next;
    logic              tx_start_reg;
    logic [2:0]        dig_sel_reg;
    logic [1:0]        tx_byte_sel_reg;

    assign last_byte = (byte_cnt_reg == BYTE_W'(DIGEST_BYTES - 1));

    // The counter only lives inside the transmit states; anywhere else it is
    // held at zero, so entering TX_START from UPDATE always begins at byte 0
    // and the select outputs read zero outside transmission.
    always_comb begin
        byte_cnt_next = '0;
        if (is_tx(state_next)) begin
            byte_cnt_next = byte_cnt_reg;
            if ((state_reg == ST_TX_WAIT) && tx_done_in && !last_byte) begin
                byte_cnt_next = byte_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            byte_cnt_reg    <= '0;
            tx_start_reg    <= 1'b0;
            dig_sel_reg     <= '0;
            tx_byte_sel_reg <= '0;
        end else begin
            byte_cnt_reg    <= byte_cnt_next;
            tx_start_reg    <= (state_next == ST_TX_START);
            dig_sel_reg     <= byte_cnt_next[4:2];
            tx_byte_sel_reg <= byte_cnt_next[1:0];
        end
    end

    assign tx_start    = tx_start_reg;
    assign dig_sel     = dig_sel_reg;
    assign tx_byte_sel = tx_byte_sel_reg;

endmodule

// File: rtl/sha256_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_ctrl
// Control FSM for a SHA-256 core: loads 16 message words from a packer into
// the schedule memory, strobes the compression rounds, triggers the hash
// update and streams the 32 digest bytes to a UART transmitter.
// Parameters:
//   ROUNDS      compression rounds per block (1..64)
//   WDOG_LIMIT  idle cycles tolerated in LOAD (watchdog build only)
// Build option:
//   SHA256_CTRL_WDOG_EN  when defined, LOAD aborts to ERR after WDOG_LIMIT
//                        consecutive cycles without mp_dv_in
// Ports:
//   clk, rst_n                       clock; sync active-high reset (1 = reset)
//   mp_dv_in/mp_data_in/mp_count_in  packer word valid / data / index
//   w_load_en/w_addr/w_data_out      schedule write, one cycle after accept
//   hash_init                        pulse: load initial hash constants
//   round_en/round_idx               round strobe and round number
//   hash_update                      pulse: add working variables into H
//   tx_start/dig_sel/tx_byte_sel     transmitter start and byte select
//   tx_done_in                       transmitter byte-complete pulse
//   busy/done/error                  status; done/error are one-cycle pulses
// All outputs are registered.
// -----------------------------------------------------------------------------
module sha256_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int ROUNDS     = 64,
    parameter int WDOG_LIMIT = 4340
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mp_dv_in,
    input  logic [31:0] mp_data_in,
    input  logic [7:0]  mp_count_in,
    output logic        w_load_en,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data_out,
    output logic        hash_init,
    output logic        round_en,
    output logic [5:0]  round_idx,
    output logic        hash_update,
    output logic        tx_start,
    output logic [2:0]  dig_sel,
    output logic [1:0]  tx_byte_sel,
    input  logic        tx_done_in,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Elaboration-time sanity check on the configuration.
    if (ROUNDS < 1 || ROUNDS > NUM_ROUNDS || WDOG_LIMIT < 1) begin : g_param_check
        $error("sha256_ctrl: ROUNDS must be 1..64 and WDOG_LIMIT >= 1");
    end

    state_t      state_reg, state_next;
    logic [3:0]  last_idx_reg, last_idx_next;
    logic [5:0]  round_cnt_reg, round_cnt_next;
    logic        accept;
    logic        last_byte;

    logic        w_load_en_reg;
    logic [3:0]  w_addr_reg;
    logic [31:0] w_data_reg;
    logic        hash_init_reg;
    logic        round_en_reg;
    logic        hash_update_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        error_reg;

`ifdef SHA256_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
    logic              wdog_expired;

    // Counts consecutive silent LOAD cycles; any other state (including the
    // IDLE cycle that precedes LOAD entry) or any valid word clears it.
    always_comb begin
        wdog_cnt_next = '0;
        if ((state_reg == ST_LOAD) && !mp_dv_in) begin
            wdog_cnt_next = wdog_cnt_reg + 1'b1;
        end
    end

    assign wdog_expired = (wdog_cnt_reg == WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wdog_cnt_reg <= '0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_next;
        end
    end
`else
    logic wdog_expired;
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        last_idx_next  = last_idx_reg;
        round_cnt_next = round_cnt_reg;
        accept         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Only word 0 may open a block; anything else is dropped.
                if (mp_dv_in && (mp_count_in == 8'd0)) begin
                    accept        = 1'b1;
                    last_idx_next = 4'd0;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (mp_dv_in) begin
                    // Next index writes a new slot; a repeat of the last index
                    // rewrites it (the packer may resend word 0).
                    if ((mp_count_in == ({4'd0, last_idx_reg} + 8'd1)) ||
                        (mp_count_in == {4'd0, last_idx_reg})) begin
                        accept        = 1'b1;
                        last_idx_next = mp_count_in[3:0];
                        if (mp_count_in == 8'(NUM_WORDS - 1)) begin
                            state_next = ST_ROUND;
                        end
                    end else begin
                        state_next = ST_ERR;
                    end
                end else if (wdog_expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_ROUND: begin
                if (round_cnt_reg == 6'(ROUNDS - 1)) begin
                    state_next = ST_UPDATE;
                end else begin
                    round_cnt_next = round_cnt_reg + 6'd1;
                end
            end
            ST_UPDATE:   state_next = ST_TX_START;
            ST_TX_START: state_next = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (tx_done_in) begin
                    state_next = last_byte ? ST_DONE : ST_TX_START;
                end
            end
            ST_DONE:     state_next = ST_IDLE;
            ST_ERR:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase

        // Round counter is zero everywhere outside ROUND, so each ROUND entry
        // starts at round 0 and the counter never wraps.
        if (state_next != ST_ROUND) begin
            round_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg       <= ST_IDLE;
            last_idx_reg    <= '0;
            round_cnt_reg   <= '0;
            w_load_en_reg   <= 1'b0;
            w_addr_reg      <= '0;
            w_data_reg      <= '0;
            hash_init_reg   <= 1'b0;
            round_en_reg    <= 1'b0;
            hash_update_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_idx_reg    <= last_idx_next;
            round_cnt_reg   <= round_cnt_next;
            w_load_en_reg   <= accept;
            if (accept) begin
                w_addr_reg <= mp_count_in[3:0];
                w_data_reg <= mp_data_in;
            end
            hash_init_reg   <= accept && (state_reg == ST_IDLE);
            round_en_reg    <= (state_next == ST_ROUND);
            hash_update_reg <= (state_next == ST_UPDATE);
            busy_reg        <= (state_next != ST_IDLE);
            done_reg        <= (state_next == ST_DONE);
            error_reg       <= (state_next == ST_ERR);
        end
    end

    sha256_tx_seq u_tx_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .state_reg   (state_reg),
        .state_next  (state_next),
        .tx_done_in  (tx_done_in),
        .last_byte   (last_byte),
        .tx_start    (tx_start),
        .dig_sel     (dig_sel),
        .tx_byte_sel (tx_byte_sel)
    );

    assign w_load_en   = w_load_en_reg;
    assign w_addr      = w_addr_reg;
    assign w_data_out  = w_data_reg;
    assign hash_init   = hash_init_reg;
    assign round_en    = round_en_reg;
    assign round_idx   = round_cnt_reg;
    assign hash_update = hash_update_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;

endmodule
